// File: rtl/processor_if.sv
// ---------------------------------------------------------------------------
// processor_if -- memory bus between the multi-cycle core and main memory.
//
//   dataIn : 16  memory -> core  instruction word (FETCH) or load data (MEMORY)
//   busA   : 16  core -> memory  address (PC in FETCH, effective address in MEMORY)
//   busB   : 16  core -> memory  store data, 0 when not storing
//   rw     : 1   core -> memory  1 = write busB at busA, 0 = read
//
// master : the core side.  slave : the memory side.
// ---------------------------------------------------------------------------
interface processor_if;
  logic [15:0] dataIn;
  logic [15:0] busA;
  logic [15:0] busB;
  logic        rw;

  modport master (input dataIn, output busA, output busB, output rw);
  modport slave  (output dataIn, input busA, input busB, input rw);
endinterface

// File: rtl/processor.sv
// ---------------------------------------------------------------------------
// processor -- 16-bit multi-cycle core, five clocks per instruction:
//   FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH
//
// Ports
//   clk   : in   rising-edge clock
//   reset : in   synchronous, active-high reset
//   bus   : processor_if.master  (dataIn in; busA, busB, rw out)
//
// Architectural state: PC (byte address, 2-byte instructions), r0..r7
// (r0 reads as zero, writes to it are dropped), flags N Z V C.
// Register and flag updates and the PC update all happen at the edge that
// ends WRITEBACK, so every source operand sees the pre-instruction value.
//
// Optional feature: define PROCESSOR_SHIFT_EN to enable sll (op 00101) and
// srl (op 01000). Without it both opcodes behave as NOPs.
// ---------------------------------------------------------------------------
module processor (
  input  logic        clk,
  input  logic        reset,
  processor_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_e;

  localparam logic [4:0] OP_ADDCC  = 5'b00000;
  localparam logic [4:0] OP_MOV    = 5'b00001;
  localparam logic [4:0] OP_ANDCC  = 5'b00010;
  localparam logic [4:0] OP_SUBCC  = 5'b00011;
  localparam logic [4:0] OP_ORCC   = 5'b00100;
  localparam logic [4:0] OP_SLL    = 5'b00101;
  localparam logic [4:0] OP_LD     = 5'b00110;
  localparam logic [4:0] OP_ST     = 5'b00111;
  localparam logic [4:0] OP_SRL    = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b01001;
  localparam logic [4:0] OP_SETLOW = 5'b01010;
  localparam logic [4:0] OP_SETHI  = 5'b01011;

  state_e      state_q, state_d;
  logic [15:0] pc_q;
  logic [15:0] ir_q;
  logic [15:0] rf_q [8];      // entry 0 is never written and never read
  logic [3:0]  nzvc_q;        // {N, Z, V, C}

  // Results computed in EXECUTE (or MEMORY for loads), committed in WRITEBACK
  logic [15:0] res_q;
  logic [3:0]  nzvc_res_q;
  logic [15:0] tgt_q;
  logic [2:0]  wb_idx_q;
  logic        wr_q;
  logic        fl_q;
  logic        br_q;

  // Flags for an arithmetic/logic result: N from bit 15, Z on all-zero
  function automatic logic [3:0] nz_flags(input logic [15:0] r,
                                          input logic        v,
                                          input logic        c);
    return {r[15], (r == 16'h0000), v, c};
  endfunction

  // ---- decode fields ----
  logic [4:0]  op;
  logic [2:0]  rd, rs1, rs2, cond;
  logic        is_call;
  logic [15:0] rd_val, a_val, b_val, j_val;
  logic signed [15:0] disp8_s, disp14_s;

  assign op       = ir_q[15:11];
  assign rd       = ir_q[10:8];
  assign rs1      = ir_q[7:5];
  assign rs2      = ir_q[4:2];
  assign cond     = ir_q[10:8];
  assign is_call  = (ir_q[15:14] == 2'b11);
  assign disp8_s  = {{8{ir_q[7]}}, ir_q[7:0]};
  assign disp14_s = {{2{ir_q[13]}}, ir_q[13:0]};

  // Register read ports; r0 is hard-wired to zero
  assign rd_val = (rd  == 3'd0)       ? 16'h0000 : rf_q[rd];
  assign a_val  = (rs1 == 3'd0)       ? 16'h0000 : rf_q[rs1];
  assign b_val  = (rs2 == 3'd0)       ? 16'h0000 : rf_q[rs2];
  assign j_val  = (ir_q[2:0] == 3'd0) ? 16'h0000 : rf_q[ir_q[2:0]];

  // ---- execute datapath ----
  logic [15:0] exe_res;
  logic [3:0]  exe_nzvc;
  logic [15:0] exe_tgt;
  logic        exe_wr, exe_fl, exe_br;
  logic [16:0] sum17, dif17;
  logic        flag_n, flag_z, flag_v, flag_c;

  assign sum17 = {1'b0, a_val} + {1'b0, b_val};
  assign dif17 = {1'b0, a_val} - {1'b0, b_val};   // bit 16 is the borrow
  assign {flag_n, flag_z, flag_v, flag_c} = nzvc_q;

  always_comb begin
    exe_res  = 16'h0000;
    exe_nzvc = nzvc_q;
    exe_tgt  = 16'h0000;
    exe_wr   = 1'b0;
    exe_fl   = 1'b0;
    exe_br   = 1'b0;
    if (is_call) begin
      exe_res = pc_q + 16'd2;
      exe_wr  = 1'b1;
      exe_br  = 1'b1;
      exe_tgt = (pc_q + $unsigned(disp14_s)) & 16'hFFFE;
    end else begin
      case (op)
        OP_ADDCC: begin
          exe_res  = sum17[15:0];
          exe_nzvc = nz_flags(sum17[15:0],
                              (a_val[15] == b_val[15]) && (sum17[15] != a_val[15]),
                              sum17[16]);
          exe_wr   = 1'b1;
          exe_fl   = 1'b1;
        end
        OP_SUBCC: begin
          exe_res  = dif17[15:0];
          exe_nzvc = nz_flags(dif17[15:0],
                              (a_val[15] != b_val[15]) && (dif17[15] != a_val[15]),
                              dif17[16]);
          exe_wr   = 1'b1;
          exe_fl   = 1'b1;
        end
        OP_ANDCC: begin
          exe_res  = a_val & b_val;
          exe_nzvc = nz_flags(a_val & b_val, 1'b0, 1'b0);
          exe_wr   = 1'b1;
          exe_fl   = 1'b1;
        end
        OP_ORCC: begin
          exe_res  = a_val | b_val;
          exe_nzvc = nz_flags(a_val | b_val, 1'b0, 1'b0);
          exe_wr   = 1'b1;
          exe_fl   = 1'b1;
        end
`ifdef PROCESSOR_SHIFT_EN
        OP_SLL: begin
          exe_res  = a_val << b_val[3:0];
          exe_nzvc = nz_flags(a_val << b_val[3:0], 1'b0, 1'b0);
          exe_wr   = 1'b1;
          exe_fl   = 1'b1;
        end
        OP_SRL: begin
          exe_res  = a_val >> b_val[3:0];
          exe_nzvc = nz_flags(a_val >> b_val[3:0], 1'b0, 1'b0);
          exe_wr   = 1'b1;
          exe_fl   = 1'b1;
        end
`endif
        OP_MOV: begin
          exe_res = a_val;
          exe_wr  = 1'b1;
        end
        OP_LD: begin
          // data arrives in MEMORY and overwrites res_q there
          exe_wr = 1'b1;
        end
        OP_SETLOW: begin
          exe_res = {rd_val[15:8], ir_q[7:0]};
          exe_wr  = 1'b1;
        end
        OP_SETHI: begin
          exe_res = {ir_q[7:0], 8'h00};
          exe_wr  = 1'b1;
        end
        OP_BRANCH: begin
          exe_tgt = (pc_q + $unsigned(disp8_s)) & 16'hFFFE;
          case (cond)
            3'b000: begin
              exe_br  = 1'b1;
              exe_tgt = j_val & 16'hFFFE;
            end
            3'b001:  exe_br = 1'b1;
            3'b010:  exe_br = flag_z;
            3'b011:  exe_br = !flag_z;
            3'b100:  exe_br = flag_n;
            3'b101:  exe_br = flag_z | (flag_n ^ flag_v);
            3'b110:  exe_br = flag_c;
            default: exe_br = flag_v;
          endcase
        end
        default: ;  // st acts in MEMORY only; unused opcodes are NOPs
      endcase
    end
  end

  // ---- state sequencing ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_MEMORY;
      S_MEMORY:    state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // ---- bus outputs ----
  always_comb begin
    bus.busA = pc_q;
    bus.busB = 16'h0000;
    bus.rw   = 1'b0;
    if (state_q == S_MEMORY && !is_call) begin
      if (op == OP_LD) begin
        bus.busA = a_val;
      end else if (op == OP_ST) begin
        bus.busA = a_val;
        bus.busB = rd_val;
        bus.rw   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      nzvc_q  <= 4'h0;
      wr_q    <= 1'b0;
      fl_q    <= 1'b0;
      br_q    <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      case (state_q)
        // ---- FETCH: capture instruction ----
        S_FETCH: ir_q <= bus.dataIn;
        // ---- EXECUTE: capture results and branch decision ----
        S_EXECUTE: begin
          res_q      <= exe_res;
          nzvc_res_q <= exe_nzvc;
          tgt_q      <= exe_tgt;
          wr_q       <= exe_wr;
          fl_q       <= exe_fl;
          br_q       <= exe_br;
          wb_idx_q   <= is_call ? 3'd7 : rd;
        end
        // ---- MEMORY: capture load data ----
        S_MEMORY: begin
          if (!is_call && op == OP_LD) res_q <= bus.dataIn;
        end
        // ---- WRITEBACK: commit registers, flags, PC ----
        S_WRITEBACK: begin
          if (wr_q && wb_idx_q != 3'd0) rf_q[wb_idx_q] <= res_q;
          if (fl_q) nzvc_q <= nzvc_res_q;
          pc_q <= br_q ? tgt_q : (pc_q + 16'd2);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_processor.sv
// ---------------------------------------------------------------------------
// tb_processor -- directed program plus randomized instruction stream,
// checked against an instruction-level reference model of the core.
// ---------------------------------------------------------------------------
module tb_processor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  processor_if pif ();

  processor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  // Main memory seen by the DUT (word-indexed) and the model's own copy
  logic [15:0] mem  [0:32767];
  logic [15:0] mmem [0:32767];
  assign pif.dataIn = mem[pif.busA[15:1]];

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_r [8];
  logic [3:0]  m_f;            // {N, Z, V, C}

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [15:0] addr, input logic [15:0] w);
    mem[addr[15:1]]  = w;
    mmem[addr[15:1]] = w;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_f  = 4'h0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
  endtask

  // Executes one instruction at the ISA level
  task automatic model_step();
    logic [15:0] w, a, b, d, res, npc;
    logic [4:0]  op;
    logic [2:0]  wi;
    logic        wr, fl, take, n, z, v, c;
    int          sa, sb, s;
    w   = mmem[m_pc[15:1]];
    op  = w[15:11];
    a   = m_r[w[7:5]];
    b   = m_r[w[4:2]];
    d   = m_r[w[10:8]];
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    npc = m_pc + 16'd2;
    wi  = w[10:8];
    res = 16'h0000;
    wr = 0; fl = 0; v = 0; c = 0; take = 0;
    {n, z} = 2'b00;
    if (w[15:14] == 2'b11) begin
      s   = w[13] ? int'(w[13:0]) - 16384 : int'(w[13:0]);
      res = m_pc + 16'd2;
      wr  = 1;
      wi  = 3'd7;
      npc = 16'(int'(m_pc) + s) & 16'hFFFE;
    end else begin
      case (op)
        5'd0: begin
          s = int'(a) + int'(b); res = 16'(s); c = (s > 65535);
          v = (sa + sb > 32767) || (sa + sb < -32768); wr = 1; fl = 1;
        end
        5'd3: begin
          res = a - b; c = (a < b);
          v = (sa - sb > 32767) || (sa - sb < -32768); wr = 1; fl = 1;
        end
        5'd2: begin res = a & b; wr = 1; fl = 1; end
        5'd4: begin res = a | b; wr = 1; fl = 1; end
`ifdef PROCESSOR_SHIFT_EN
        5'd5: begin res = 16'(int'(a) << int'(b[3:0])); wr = 1; fl = 1; end
        5'd8: begin res = a >> b[3:0]; wr = 1; fl = 1; end
`endif
        5'd1:  begin res = a; wr = 1; end
        5'd6:  begin res = mmem[a[15:1]]; wr = 1; end
        5'd7:  mmem[a[15:1]] = d;
        5'd10: begin res = {d[15:8], w[7:0]}; wr = 1; end
        5'd11: begin res = {w[7:0], 8'h00}; wr = 1; end
        5'd9: begin
          case (w[10:8])
            3'd1: take = 1;
            3'd2: take = m_f[2];
            3'd3: take = !m_f[2];
            3'd4: take = m_f[3];
            3'd5: take = m_f[2] || (m_f[3] != m_f[1]);
            3'd6: take = m_f[0];
            3'd7: take = m_f[1];
            default: take = 0;
          endcase
          if (w[10:8] == 3'd0) npc = m_r[w[2:0]] & 16'hFFFE;
          else if (take) npc = 16'(int'(m_pc) + int'($signed(w[7:0]))) & 16'hFFFE;
        end
        default: ;
      endcase
    end
    if (fl) begin
      n = res[15];
      z = (res == 16'h0000);
      m_f = {n, z, v, c};
    end
    if (wr && wi != 3'd0) m_r[wi] = res;
    m_pc = npc;
  endtask

  // Runs one 5-cycle instruction; entered and left at FETCH, 1 time unit after the edge
  task automatic run_instr();
    logic [15:0] w, ea, sd;
    logic [4:0]  op;
    logic        is_call;
    w       = mmem[m_pc[15:1]];
    op      = w[15:11];
    is_call = (w[15:14] == 2'b11);
    ea      = m_r[w[7:5]];
    sd      = m_r[w[10:8]];
    check("fetch_busA", pif.busA, m_pc);
    check("fetch_rw", pif.rw, 1'b0);
    @(posedge clk); #1;
    check("decode_rw", pif.rw, 1'b0);
    @(posedge clk); #1;
    check("execute_rw", pif.rw, 1'b0);
    @(posedge clk); #1;
    if (!is_call && op == 5'b00111) begin
      check("st_busA", pif.busA, ea);
      check("st_busB", pif.busB, sd);
      check("st_rw", pif.rw, 1'b1);
      mem[pif.busA[15:1]] = pif.busB;
    end else begin
      if (!is_call && op == 5'b00110) check("ld_busA", pif.busA, ea);
      check("mem_rw", pif.rw, 1'b0);
      check("mem_busB", pif.busB, 16'h0000);
    end
    @(posedge clk); #1;
    check("wb_rw", pif.rw, 1'b0);
    @(posedge clk); #1;
    model_step();
    for (int i = 1; i < 8; i++) check($sformatf("r%0d", i), dut.rf_q[i], m_r[i]);
    check("nzvc", dut.nzvc_q, m_f);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) begin
      mem[i]  = 16'h0000;
      mmem[i] = 16'h0000;
    end
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    logic [4:0]  ops [12];
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
    w = 16'($urandom);
    if ($urandom_range(0, 3) != 0) w[15:11] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    clear_mem();

    // Directed program
    put(16'h0000, 16'h5140);  // setlow 64,%r1
    put(16'h0002, 16'h5A01);  // sethi 1,%r2
    put(16'h0004, 16'hF000);  // call -> 0xF004
    put(16'hF004, 16'h1828);  // subcc %r1,%r2,%r0
    put(16'hF006, 16'h4D06);  // ble +6
    put(16'hF00C, 16'h0B40);  // mov %r2,%r3
    put(16'hF00E, 16'h4807);  // jmp %r7
    put(16'h0006, 16'h5E08);  // sethi 8,%r6
    put(16'h0008, 16'h3BC0);  // st %r3,%r6
    put(16'h000A, 16'h046C);  // addcc %r3,%r3,%r4

    @(posedge clk); #1;
    do_reset();
    check("rst_busA", pif.busA, 16'h0000);
    check("rst_busB", pif.busB, 16'h0000);
    check("rst_rw", pif.rw, 1'b0);
    check("rst_nzvc", dut.nzvc_q, 4'h0);
    for (int i = 1; i < 8; i++) check($sformatf("rst_r%0d", i), dut.rf_q[i], 16'h0000);

    run_instr();
    run_instr();
    check("setlow_r1", dut.rf_q[1], 16'h0040);
    check("sethi_r2", dut.rf_q[2], 16'h0100);
    check("third_fetch", pif.busA, 16'h0004);
    run_instr();
    check("call_r7", dut.rf_q[7], 16'h0006);
    check("call_target", pif.busA, 16'hF004);
    run_instr();
    check("subcc_N", dut.nzvc_q[3], 1'b1);
    check("subcc_r0", dut.rf_q[0], 16'h0000);
    run_instr();
    check("ble_taken", pif.busA, 16'hF00C);
    run_instr();
    check("mov_r3", dut.rf_q[3], 16'h0100);
    run_instr();
    check("jmp_target", pif.busA, 16'h0006);
    run_instr();
    check("sethi_r6", dut.rf_q[6], 16'h0800);
    run_instr();
    check("st_memory", mem[16'h0400], 16'h0100);

    // Reset held across the edge that ends EXECUTE of the addcc
    check("addcc_fetch", pif.busA, 16'h000A);
    @(posedge clk); #1;   // DECODE
    @(posedge clk); #1;   // EXECUTE
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("midrst_busA", pif.busA, 16'h0000);
    check("midrst_r4", dut.rf_q[4], 16'h0000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("midrst_pc2", pif.busA, 16'h0002);
    check("midrst_r1", dut.rf_q[1], 16'h0040);
    model_step();

    // Not-taken ble with r1 > r2
    clear_mem();
    put(16'h0000, 16'h5902);  // sethi 2,%r1
    put(16'h0002, 16'h5A01);  // sethi 1,%r2
    put(16'h0004, 16'h1828);  // subcc %r1,%r2,%r0
    put(16'h0006, 16'h4D06);  // ble +6
    do_reset();
    repeat (4) run_instr();
    check("ble_not_taken", pif.busA, 16'h0008);

    // Randomized instruction stream
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] w;
      w = rnd_word();
      mem[i]  = w;
      mmem[i] = w;
    end
    do_reset();
    repeat (400) run_instr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
